// File: rtl/hazard_stall_unit.sv
// Load-use / branch hazard controller beside the ID stage of a 5-stage MIPS pipeline.
// Latency: stall outputs are Mealy (same cycle as detect); total stall = LOAD_LAT cycles; flush = 1 cycle.
// Backpressure: deasserts PCWrite/IFIDWrite to hold IF and ID; HazardControl inserts an ID/EX bubble.
//
// Ports:
//   Clk, Reset         - pipeline clock, synchronous active-high reset
//   IDEX_MemRead/Rt    - load in EX and its destination register
//   IFID_Rs/Rt/UsesRt  - source registers of the ID instruction (UsesRt qualifies Rt)
//   BranchTaken        - branch/jump resolved taken this cycle
//   PCWrite, IFIDWrite - hold enables (1 = update)
//   HazardControl      - zero control into ID/EX
//   IFIDFlush          - clear IF/ID to NOP on next edge
//   StallActive        - FSM is in STALL
// Optional build macro HAZARD_PERF_CNT_EN adds StallCycles[31:0] and FlushCount[15:0].
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  BranchTaken,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  HazardControl,
  output logic                  IFIDFlush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           StallCycles,
  output logic [15:0]           FlushCount,
`endif
  output logic                  StallActive
);

  generate
    if ((LOAD_LAT < 1) || (LOAD_LAT > (2 ** CNT_W) - 1)) begin : g_bad_load_lat
      $error("hazard_stall_unit: LOAD_LAT must be in 1..2^CNT_W-1");
    end
  endgenerate

  // The detect cycle already counts as the first stall cycle, so the STALL
  // state only covers the remaining LOAD_LAT-1 cycles (counter loads LOAD_LAT-2).
  localparam bit               MULTI_CYCLE = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = MULTI_CYCLE ? CNT_W'(LOAD_LAT - 2) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hz;

  // x0 is hard-wired zero, so a load "to" it never creates a dependency.
  assign hz = IDEX_MemRead && (IDEX_Rt != '0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    PCWrite       = 1'b1;
    IFIDWrite     = 1'b1;
    HazardControl = 1'b0;
    IFIDFlush     = 1'b0;
    StallActive   = 1'b0;

    case (state)
      IDLE: begin
        // A taken branch squashes the ID instruction, so its hazard is moot.
        if (BranchTaken) begin
          state_nxt = FLUSH;
        end else if (hz) begin
          PCWrite       = 1'b0;
          IFIDWrite     = 1'b0;
          HazardControl = 1'b1;
          if (MULTI_CYCLE) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_INIT;
          end
        end
      end

      STALL: begin
        PCWrite       = 1'b0;
        IFIDWrite     = 1'b0;
        HazardControl = 1'b1;
        StallActive   = 1'b1;
        // hz is not re-checked here: the bubble now in EX cannot re-fire it.
        if (BranchTaken) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      FLUSH: begin
        HazardControl = 1'b1;
        IFIDFlush     = 1'b1;
        state_nxt     = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Reset overrides everything so a reset cycle never stalls or flushes.
    if (Reset) begin
      PCWrite       = 1'b1;
      IFIDWrite     = 1'b1;
      HazardControl = 1'b0;
      IFIDFlush     = 1'b0;
      StallActive   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (!PCWrite) begin
        StallCycles <= StallCycles + 32'd1;
      end
      // FLUSH always returns to IDLE, so every cycle heading into it is an entry.
      if (state_nxt == FLUSH) begin
        FlushCount <= FlushCount + 16'd1;
      end
    end
  end
`endif

endmodule
